sc_et_counter: RTL and testbench
================================

Name: sc_et_counter

Overview:
- Multi-channel stochastic-to-binary decoder with early termination; the receiving end of the LFSR comparator SNG path.
- Counts ones on NUM_INPUTS parallel bitstreams over a programmable power-of-two window of 2^k samples.
- Rescales each count to a WIDTH-bit binary estimate of the originating Bx.
- Returns results to the controller with a valid/ready handshake.

Parameters:
- WIDTH, 8, binary value width; the full-precision window is 2^WIDTH samples.
- NUM_INPUTS, 8, number of parallel bitstreams decoded together.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  begin a new decode window; honoured only in IDLE.
- et_log2  input  $clog2(WIDTH+1)  window exponent k; window length is 2^k samples; captured on accepted start.
- Xs_valid  input  1  Xs carries a valid sample this cycle.
- Xs  input  NUM_INPUTS  one stochastic bit per channel.
- busy  output  1  high in ACCUM and HOLD.
- out_valid  output  1  Bx_est holds a finished result.
- out_ready  input  1  consumer accepts the result.
- Bx_est  output  unpacked array [NUM_INPUTS-1:0] of WIDTH bits, per-channel estimate.

Behaviour:
- Reset (rst_n low at posedge clk):
  - state goes to IDLE.
  - busy=0, out_valid=0, all Bx_est=0, all counters=0.
  - Reset takes priority in every state; a window in progress is discarded with no output.
- IDLE:
  - start=1 captures k_r = min(et_log2, WIDTH).
  - Clears the per-channel counts cnt[i] (WIDTH+1 bits) and the sample counter scnt (WIDTH+1 bits).
  - Moves to ACCUM.
  - Xs is not sampled in the start cycle.
- ACCUM:
  - On each cycle with Xs_valid=1: cnt[i] += Xs[i] and scnt += 1.
  - Cycles with Xs_valid=0 change nothing.
  - When the sample being accepted is number 2^k_r (scnt == 2^k_r - 1 before increment), that posedge does three things: accumulates the final sample, loads Bx_est, and moves to HOLD.
  - out_valid is high from the next cycle.
  - Minimum latency from accepted start to out_valid: 2^k_r + 1 cycles.
- Bx_est arithmetic:
  - Bx_est[i] = cnt_final[i] << (WIDTH - k_r), computed in WIDTH+1 bits.
  - A result equal to 2^WIDTH saturates to 2^WIDTH - 1; no other result can overflow.
  - k_r = 0: a single sample; 1 gives 2^WIDTH-1 (saturated), 0 gives 0.
- HOLD:
  - out_valid=1; Bx_est is stable; Xs is ignored.
  - out_valid & out_ready at a posedge: out_valid falls the next cycle and state returns to IDLE.
  - Bx_est keeps its last value until the next window completes.
- start:
  - start while busy (ACCUM or HOLD) is ignored; no restart and no change to k_r.
  - start in the same cycle as the HOLD→IDLE handshake is ignored; a new start is needed in IDLE.
- et_log2 changes after capture have no effect until the next accepted start.

Test Plan:
- WIDTH=8, NUM_INPUTS=2, et_log2=8, start, then 256 valid samples with Xs[0]=1 constant and Xs[1] alternating 1,0 → out_valid asserted 257 cycles after start; Bx_est[0]=255 (saturated from 256), Bx_est[1]=128.
- et_log2=4, 16 valid samples, Xs[0] has 5 ones, Xs[1] has 0 ones → Bx_est[0]=80, Bx_est[1]=0.
- et_log2=2, 4 valid samples interleaved with 3 Xs_valid=0 cycles, with Xs=2'b01 on the invalid cycles and Xs=2'b10 on the valid ones → Bx_est[0]=0, Bx_est[1]=255; out_valid 8 cycles after start.
- et_log2=0, Xs=2'b01 → Bx_est[0]=255, Bx_est[1]=0 two cycles after start; et_log2=12 → behaves as 8 (256 samples).
- Backpressure: out_ready held low for 10 cycles in HOLD, start pulsed meanwhile → out_valid and Bx_est stable throughout, start ignored; out_ready=1 → out_valid=0 next cycle, busy=0.
- rst_n low for one cycle mid-ACCUM after 100 samples → busy=0, out_valid=0, Bx_est=0; a fresh start with et_log2=3 and 8 ones → Bx_est=255, with no residue from the aborted window.

Source files
------------

// File: rtl/sc_et_counter.sv
// Multi-channel stochastic-to-binary decoder: counts ones per channel over a
// 2^k-sample window and returns a rescaled WIDTH-bit estimate with valid/ready.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | waiting for start; last result still visible on Bx_est
//   S_ACCUM | counting ones on valid samples until 2^k_r have been taken
//   S_HOLD  | result valid, waiting for out_ready
module sc_et_counter #(
    parameter int WIDTH      = 8,
    parameter int NUM_INPUTS = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [$clog2(WIDTH+1)-1:0]   et_log2,
    input  logic                         Xs_valid,
    input  logic [NUM_INPUTS-1:0]        Xs,
    output logic                         busy,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             Bx_est [NUM_INPUTS-1:0]
);

    localparam int KW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH:0]   scnt_q, scnt_d;
    logic [WIDTH:0]   cnt_q [NUM_INPUTS];
    logic [WIDTH:0]   cnt_d [NUM_INPUTS];
    logic [WIDTH-1:0] bx_q  [NUM_INPUTS];
    logic [WIDTH-1:0] bx_d  [NUM_INPUTS];

    logic [KW-1:0]    k_cap;
    logic [WIDTH:0]   window_last;
    logic             last_sample;

    // The count never exceeds 2^k, so after scaling only exactly 2^WIDTH can overflow.
    function automatic logic [WIDTH-1:0] scale_count(input logic [WIDTH:0] c,
                                                     input logic [KW-1:0] k);
        logic [WIDTH:0] s;
        s = c << (KW'(WIDTH) - k);
        return s[WIDTH] ? {WIDTH{1'b1}} : s[WIDTH-1:0];
    endfunction

    always_comb begin
        k_cap       = (et_log2 > KW'(WIDTH)) ? KW'(WIDTH) : et_log2;
        window_last = ((WIDTH+1)'(1) << k_q) - (WIDTH+1)'(1);
        last_sample = Xs_valid && (scnt_q == window_last);
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        scnt_d  = scnt_q;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            cnt_d[i] = cnt_q[i];
            bx_d[i]  = bx_q[i];
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    k_d    = k_cap;
                    scnt_d = '0;
                    for (int i = 0; i < NUM_INPUTS; i++) begin
                        cnt_d[i] = '0;
                    end
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (Xs_valid) begin
                    scnt_d = scnt_q + (WIDTH+1)'(1);
                    for (int i = 0; i < NUM_INPUTS; i++) begin
                        cnt_d[i] = cnt_q[i] + (WIDTH+1)'(Xs[i]);
                    end
                    if (last_sample) begin
                        for (int i = 0; i < NUM_INPUTS; i++) begin
                            bx_d[i] = scale_count(cnt_d[i], k_q);
                        end
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            scnt_q  <= '0;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                cnt_q[i] <= '0;
                bx_q[i]  <= '0;
            end
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            scnt_q  <= scnt_d;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                cnt_q[i] <= cnt_d[i];
                bx_q[i]  <= bx_d[i];
            end
        end
    end

    assign busy      = (state_q == S_ACCUM) || (state_q == S_HOLD);
    assign out_valid = (state_q == S_HOLD);

    always_comb begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
            Bx_est[i] = bx_q[i];
        end
    end

endmodule

// File: tb/tb_sc_et_counter.sv
// Bench for sc_et_counter (WIDTH=8, two channels): directed windows plus
// randomized windows checked against a count-and-scale reference model.
module tb_sc_et_counter;

    localparam int W  = 8;
    localparam int N  = 2;
    localparam int KW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [KW-1:0] et_log2 = '0;
    logic          xs_valid = 1'b0;
    logic [N-1:0]  xs = '0;
    logic          busy;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  bx [N-1:0];

    int errors = 0;
    int checks = 0;

    // each entry: {valid, Xs[1], Xs[0]}
    logic [2:0] stim_q [$];
    int exp_lat;
    int exp_bx [N];

    sc_et_counter #(.WIDTH(W), .NUM_INPUTS(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .et_log2   (et_log2),
        .Xs_valid  (xs_valid),
        .Xs        (xs),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Bx_est    (bx)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Xs is driven valid in the start cycle on purpose: it must not be counted.
    task automatic start_window(input int k);
        et_log2  = KW'(k);
        start    = 1'b1;
        xs_valid = 1'b1;
        xs       = 2'b11;
        tick();
        start    = 1'b0;
        xs_valid = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // Reference: take the first 2^min(k,W) valid samples, count ones, scale, clip.
    task automatic model_expect(input int k);
        int keff, need, nv, v;
        int ones [N];
        keff = (k > W) ? W : k;
        need = 1 << keff;
        nv = 0;
        exp_lat = -1;
        for (int c = 0; c < N; c++) ones[c] = 0;
        for (int i = 0; i < stim_q.size(); i++) begin
            if (stim_q[i][2] && nv < need) begin
                nv++;
                for (int c = 0; c < N; c++) ones[c] += int'(stim_q[i][c]);
                if (nv == need) exp_lat = i + 2;
            end
        end
        for (int c = 0; c < N; c++) begin
            v = ones[c] * (1 << (W - keff));
            exp_bx[c] = (v > (1 << W) - 1) ? (1 << W) - 1 : v;
        end
    endtask

    // Plays the queued samples until out_valid rises; lat counts cycles from the start cycle.
    task automatic run_items(output int lat);
        logic [2:0] it;
        lat = 1;
        while (!out_valid && lat < 2000) begin
            if (stim_q.size() > 0) begin
                it = stim_q.pop_front();
                xs_valid = it[2];
                xs = it[1:0];
            end else begin
                xs_valid = 1'b0;
                xs = 2'(($urandom));
            end
            tick();
            lat++;
        end
        xs_valid = 1'b0;
        stim_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        for (int c = 0; c < N; c++) begin
            checks++;
            if (bx[c] !== 8'd0) begin errors++; $display("FAIL reset_bx%0d: got %0d want 0", c, bx[c]); end
        end
    endtask

    task automatic test_full_window();
        int lat;
        for (int i = 0; i < 256; i++) stim_q.push_back({1'b1, (i % 2 == 0), 1'b1});
        start_window(8);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL full_busy: got %b want 1", busy); end
        run_items(lat);
        checks++;
        if (lat != 257) begin errors++; $display("FAIL full_latency: got %0d want 257", lat); end
        checks++;
        if (bx[0] !== 8'd255) begin errors++; $display("FAIL full_bx0: got %0d want 255", bx[0]); end
        checks++;
        if (bx[1] !== 8'd128) begin errors++; $display("FAIL full_bx1: got %0d want 128", bx[1]); end
        handshake();
    endtask

    task automatic test_k4();
        int lat, cnt, p;
        logic [15:0] bits;
        bits = '0;
        cnt = 0;
        while (cnt < 5) begin
            p = $urandom_range(15, 0);
            if (!bits[p]) begin bits[p] = 1'b1; cnt++; end
        end
        for (int i = 0; i < 16; i++) stim_q.push_back({1'b1, 1'b0, bits[i]});
        start_window(4);
        run_items(lat);
        checks++;
        if (lat != 17) begin errors++; $display("FAIL k4_latency: got %0d want 17", lat); end
        checks++;
        if (bx[0] !== 8'd80) begin errors++; $display("FAIL k4_bx0: got %0d want 80", bx[0]); end
        checks++;
        if (bx[1] !== 8'd0) begin errors++; $display("FAIL k4_bx1: got %0d want 0", bx[1]); end
        handshake();
    endtask

    task automatic test_interleave();
        int lat;
        for (int i = 0; i < 7; i++) begin
            if (i % 2 == 0) stim_q.push_back(3'b110);
            else            stim_q.push_back(3'b001);
        end
        start_window(2);
        run_items(lat);
        checks++;
        if (lat != 8) begin errors++; $display("FAIL gap_latency: got %0d want 8", lat); end
        checks++;
        if (bx[0] !== 8'd0) begin errors++; $display("FAIL gap_bx0: got %0d want 0", bx[0]); end
        checks++;
        if (bx[1] !== 8'd255) begin errors++; $display("FAIL gap_bx1: got %0d want 255", bx[1]); end
        handshake();
    endtask

    task automatic test_k0_and_clamp();
        int lat;
        stim_q.push_back(3'b101);
        start_window(0);
        run_items(lat);
        checks++;
        if (lat != 2) begin errors++; $display("FAIL k0_latency: got %0d want 2", lat); end
        checks++;
        if (bx[0] !== 8'd255) begin errors++; $display("FAIL k0_bx0: got %0d want 255", bx[0]); end
        checks++;
        if (bx[1] !== 8'd0) begin errors++; $display("FAIL k0_bx1: got %0d want 0", bx[1]); end
        handshake();
        for (int i = 0; i < 270; i++) stim_q.push_back({1'b1, 2'(($urandom))});
        model_expect(12);
        start_window(12);
        run_items(lat);
        checks++;
        if (lat != 257) begin errors++; $display("FAIL clamp_latency: got %0d want 257", lat); end
        for (int c = 0; c < N; c++) begin
            checks++;
            if (int'(bx[c]) != exp_bx[c]) begin errors++; $display("FAIL clamp_bx%0d: got %0d want %0d", c, bx[c], exp_bx[c]); end
        end
        handshake();
    endtask

    task automatic test_backpressure();
        int lat;
        stim_q.push_back(3'b111);
        stim_q.push_back(3'b111);
        start_window(1);
        run_items(lat);
        checks++;
        if (lat != 3) begin errors++; $display("FAIL bp_latency: got %0d want 3", lat); end
        for (int j = 0; j < 10; j++) begin
            out_ready = 1'b0;
            start = (j == 3);
            et_log2 = 4'd5;
            xs_valid = 1'b1;
            xs = 2'b00;
            tick();
            start = 1'b0;
            checks++;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", j, out_valid); end
            checks++;
            if (bx[0] !== 8'd255 || bx[1] !== 8'd255) begin
                errors++; $display("FAIL bp_hold_bx[%0d]: got %0d,%0d want 255,255", j, bx[0], bx[1]);
            end
        end
        xs_valid = 1'b0;
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        out_ready = 1'b0;
        start = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL bp_release_busy: got %b want 0", busy); end
        tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL bp_start_at_handshake: busy got %b want 0", busy); end
        checks++;
        if (bx[0] !== 8'd255 || bx[1] !== 8'd255) begin
            errors++; $display("FAIL bp_retain_bx: got %0d,%0d want 255,255", bx[0], bx[1]);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        start_window(8);
        for (int i = 0; i < 100; i++) begin
            xs_valid = 1'b1;
            xs = 2'b11;
            tick();
        end
        xs_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL midreset_flags: got busy=%b valid=%b want 0,0", busy, out_valid);
        end
        checks++;
        if (bx[0] !== 8'd0 || bx[1] !== 8'd0) begin
            errors++; $display("FAIL midreset_bx: got %0d,%0d want 0,0", bx[0], bx[1]);
        end
        for (int i = 0; i < 8; i++) stim_q.push_back(3'b111);
        start_window(3);
        run_items(lat);
        checks++;
        if (lat != 9) begin errors++; $display("FAIL midreset_latency: got %0d want 9", lat); end
        checks++;
        if (bx[0] !== 8'd255 || bx[1] !== 8'd255) begin
            errors++; $display("FAIL midreset_bx_new: got %0d,%0d want 255,255", bx[0], bx[1]);
        end
        handshake();
    endtask

    task automatic test_random();
        int lat, k, keff, need, nv, dens, wait_n;
        logic v;
        for (int it = 0; it < 25; it++) begin
            k = $urandom_range(15, 0);
            keff = (k > W) ? W : k;
            need = 1 << keff;
            dens = $urandom_range(4, 1);
            nv = 0;
            while (nv < need + 2) begin
                v = ($urandom_range(3, 0) < dens);
                if (v) nv++;
                stim_q.push_back({v, 2'(($urandom))});
            end
            model_expect(k);
            start_window(k);
            run_items(lat);
            checks++;
            if (lat != exp_lat) begin errors++; $display("FAIL rnd%0d_latency: k=%0d got %0d want %0d", it, k, lat, exp_lat); end
            for (int c = 0; c < N; c++) begin
                checks++;
                if (int'(bx[c]) != exp_bx[c]) begin
                    errors++; $display("FAIL rnd%0d_bx%0d: k=%0d got %0d want %0d", it, c, k, bx[c], exp_bx[c]);
                end
            end
            wait_n = $urandom_range(3, 0);
            repeat (wait_n) tick();
            checks++;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL rnd%0d_hold: got %b want 1", it, out_valid); end
            handshake();
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL rnd%0d_release: got %b want 0", it, out_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_full_window();
        test_k4();
        test_interleave();
        test_k0_and_clamp();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
